// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin sharing of the single combinational address adder
// among the fetch PC increment, branch target and jump/JAL target requesters.
// The winner drives the adder operands this cycle; the result is registered and
// returned to the winner one cycle later with a one-hot response strobe.
module adder_arbiter #(
  parameter int WORD = 16,
  parameter int NREQ = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*WORD-1:0] req_a,
  input  logic [NREQ*WORD-1:0] req_b,
  input  logic [NREQ*4-1:0]    req_op,
  input  logic                 flush,
  output logic [NREQ-1:0]      gnt,
  output logic [WORD-1:0]      add_a,
  output logic [WORD-1:0]      add_b,
  output logic [3:0]           add_op,
  input  logic [WORD-1:0]      add_result,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [WORD-1:0]      rsp_data,
  output logic [15:0]          op_count
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] win_idx;
  logic [PW-1:0] scan_idx;
  logic [PW-1:0] ptr_next;
  logic          win_valid;

  // Search for the first requester starting at the rotating pointer; reset and
  // flush block issue entirely.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    if (reset_n && !flush) begin
      for (int k = 0; k < NREQ; k++) begin
        scan_idx = PW'((int'(ptr) + k) % NREQ);
        if (!win_valid && req[scan_idx]) begin
          win_valid = 1'b1;
          win_idx   = scan_idx;
        end
      end
    end
  end

  // One-hot grant and operand mux; an idle adder sees all-zero operands.
  always_comb begin
    gnt    = '0;
    add_a  = '0;
    add_b  = '0;
    add_op = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_valid && (win_idx == PW'(i))) begin
        gnt[i] = 1'b1;
        add_a  = req_a[i*WORD +: WORD];
        add_b  = req_b[i*WORD +: WORD];
        add_op = req_op[i*4 +: 4];
      end
    end
  end

  // Pointer moves to the requester just after the winner, wrapping at NREQ.
  always_comb begin
    ptr_next = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
  end

  // Capture the adder result for the winner; the strobe lasts a single cycle
  // while rsp_data holds until the next issue.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr       <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      op_count  <= '0;
    end else if (win_valid) begin
      ptr       <= ptr_next;
      rsp_valid <= gnt;
      rsp_data  <= add_result;
      if (op_count != 16'hFFFF) op_count <= op_count + 16'd1;
    end else begin
      rsp_valid <= '0;
    end
  end

endmodule
